// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus field widths.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_t;
endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Pad-side I2C lines plus host register read port and write-commit notification.
interface i2c_slave_regfile_if
  import i2c_pkg::*;
#(
  parameter int PTR_W = 4
);
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic [PTR_W-1:0]      host_idx;
  logic [I2C_BYTE_W-1:0] host_rdata;
  logic                  wr_strobe;
  logic [PTR_W-1:0]      wr_idx;
  logic [I2C_BYTE_W-1:0] wr_data;
  logic                  busy;

  modport slave (
    input  scl_i, sda_i, host_idx,
    output sda_oe, host_rdata, wr_strobe, wr_idx, wr_data, busy
  );

  modport master (
    output scl_i, sda_i, host_idx,
    input  sda_oe, host_rdata, wr_strobe, wr_idx, wr_data, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with registered SCL edge and START/STOP pulses.
// Latency SYNC_STAGES + 1 clk from pin to pulse; no backpressure, pulses are single-cycle.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Reset to the idle-high bus level so release of reset creates no false START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      o_scl_rise <= 1'b0;
      o_scl_fall <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
      o_sda      <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      o_scl_rise <= w_scl & ~r_scl_d;
      o_scl_fall <= ~w_scl & r_scl_d;
      o_start    <= r_sda_d & ~w_sda & w_scl;
      o_stop     <= ~r_sda_d & w_sda & w_scl;
      o_sda      <= w_sda;
    end
  end
endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with pointer-addressed byte register file, burst read/write and repeated START.
// sda_oe moves 1 clk after a detected SCL fall; wr_strobe 1 clk after the 8th data rise; no backpressure.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h78,
  parameter int                    NUM_REGS    = 16,
  parameter int                    SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  i2c_slave_regfile_if.slave bus
);
  localparam int PTR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  logic w_rise, w_fall, w_start, w_stop, w_sda;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_scl     (bus.scl_i),
    .i_sda     (bus.sda_i),
    .o_scl_rise(w_rise),
    .o_scl_fall(w_fall),
    .o_start   (w_start),
    .o_stop    (w_stop),
    .o_sda     (w_sda)
  );

  i2c_state_t            r_state, w_nxt_state;
  logic [2:0]            r_cnt, w_nxt_cnt;
  logic [I2C_BYTE_W-1:0] r_shift, w_nxt_shift;
  logic [PTR_W-1:0]      r_ptr, w_nxt_ptr;
  logic                  r_rw, w_nxt_rw;
  logic                  r_ack_on, w_nxt_ack_on;
  logic                  r_sda_oe, w_nxt_sda_oe;
  logic                  r_busy, w_nxt_busy;
  logic                  r_wr_strobe, w_nxt_wr_strobe;
  logic [PTR_W-1:0]      r_wr_idx, w_nxt_wr_idx;
  logic [I2C_BYTE_W-1:0] r_wr_data, w_nxt_wr_data;
  logic [I2C_BYTE_W-1:0] r_regs [NUM_REGS];
  logic [I2C_BYTE_W-1:0] w_byte;
  logic [PTR_W-1:0]      w_ptr_inc;
  logic                  w_match;

  assign w_byte    = {r_shift[I2C_BYTE_W-2:0], w_sda};
  assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_shift     = r_shift;
    w_nxt_ptr       = r_ptr;
    w_nxt_rw        = r_rw;
    w_nxt_ack_on    = r_ack_on;
    w_nxt_sda_oe    = r_sda_oe;
    w_nxt_wr_strobe = 1'b0;
    w_nxt_wr_idx    = r_wr_idx;
    w_nxt_wr_data   = r_wr_data;
    w_match         = 1'b0;
    if (w_stop) begin
      w_nxt_state  = IDLE;
      w_nxt_cnt    = '0;
      w_nxt_ack_on = 1'b0;
      w_nxt_sda_oe = 1'b0;
    end else if (w_start) begin
      w_nxt_state  = ADDR;
      w_nxt_cnt    = '0;
      w_nxt_ack_on = 1'b0;
      w_nxt_sda_oe = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR, PTR, WR_DATA: begin
          if (w_rise) begin
            w_nxt_shift  = w_byte;
            w_nxt_cnt    = r_cnt + 3'd1;
            w_nxt_ack_on = 1'b0;
            if (r_cnt == 3'd7) begin
              if (r_state == ADDR) begin
                if (w_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                  w_match     = 1'b1;
                  w_nxt_rw    = w_byte[0];
                  w_nxt_state = ADDR_ACK;
                end else begin
                  w_nxt_state = IDLE;
                end
              end else if (r_state == PTR) begin
                if ({1'b0, w_byte} < 9'(NUM_REGS)) begin
                  w_nxt_ptr   = w_byte[PTR_W-1:0];
                  w_nxt_state = PTR_ACK;
                end else begin
                  w_nxt_state = IDLE;
                end
              end else begin
                w_nxt_wr_strobe = 1'b1;
                w_nxt_wr_idx    = r_ptr;
                w_nxt_wr_data   = w_byte;
                w_nxt_ptr       = w_ptr_inc;
                w_nxt_state     = WR_ACK;
              end
            end
          end
        end
        // First fall after the byte starts the ACK, the second one ends it.
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (w_fall) begin
            if (!r_ack_on) begin
              w_nxt_sda_oe = 1'b1;
              w_nxt_ack_on = 1'b1;
            end else begin
              w_nxt_ack_on = 1'b0;
              w_nxt_cnt    = '0;
              if (r_state == ADDR_ACK && r_rw) begin
                w_nxt_state  = RD_DATA;
                w_nxt_shift  = r_regs[r_ptr];
                w_nxt_sda_oe = ~r_regs[r_ptr][I2C_BYTE_W-1];
              end else begin
                w_nxt_sda_oe = 1'b0;
                w_nxt_state  = (r_state == ADDR_ACK) ? PTR : WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (w_rise) begin
            w_nxt_shift = {r_shift[I2C_BYTE_W-2:0], 1'b0};
            w_nxt_cnt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_nxt_state = RD_ACK;
              w_nxt_ptr   = w_ptr_inc;
            end
          end else if (w_fall) begin
            if (r_cnt == 3'd0) begin
              w_nxt_shift  = r_regs[r_ptr];
              w_nxt_sda_oe = ~r_regs[r_ptr][I2C_BYTE_W-1];
            end else begin
              w_nxt_sda_oe = ~r_shift[I2C_BYTE_W-1];
            end
          end
        end
        RD_ACK: begin
          if (w_fall) begin
            w_nxt_sda_oe = 1'b0;
          end else if (w_rise) begin
            w_nxt_cnt   = '0;
            w_nxt_state = w_sda ? IDLE : RD_DATA;
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
    w_nxt_busy = (w_nxt_state == IDLE) ? 1'b0 : (w_match | r_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_cnt       <= w_nxt_cnt;
      r_shift     <= w_nxt_shift;
      r_ptr       <= w_nxt_ptr;
      r_rw        <= w_nxt_rw;
      r_ack_on    <= w_nxt_ack_on;
      r_sda_oe    <= w_nxt_sda_oe;
      r_busy      <= w_nxt_busy;
      r_wr_strobe <= w_nxt_wr_strobe;
      r_wr_idx    <= w_nxt_wr_idx;
      r_wr_data   <= w_nxt_wr_data;
      if (r_wr_strobe) r_regs[r_wr_idx] <= r_wr_data;
    end
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.busy       = r_busy;
  assign bus.wr_strobe  = r_wr_strobe;
  assign bus.wr_idx     = r_wr_idx;
  assign bus.wr_data    = r_wr_data;
  assign bus.host_rdata = ({1'b0, bus.host_idx} < (PTR_W + 1)'(NUM_REGS)) ? r_regs[bus.host_idx] : '0;
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C target with a byte-wide register file, running entirely in the system clock domain by oversampling SCL/SDA. It is the next generation of our fixed-address, single-byte I2C slave. It adds a configurable address, a register pointer with auto-increment, multi-byte burst read/write, repeated START, and a host-side register access port. It sits behind the open-drain pad logic and feeds control/status registers to the rest of the design.

## Interface
- `SLAVE_ADDR`, 7'h78, 7-bit target address
- `NUM_REGS`, 16, number of 8-bit registers (2..256); pointer width `PTR_W = max(1, clog2(NUM_REGS))`
- `SYNC_STAGES`, 2, synchroniser depth on `scl_i`/`sda_i` (>=2)
- `clk` input 1: system clock, must be >= 8x SCL frequency
- `rst_n` input 1: asynchronous, active-low reset
- `scl_i` input 1: SCL pad input
- `sda_i` input 1: SDA pad input
- `sda_oe` output 1: 1 = pull SDA low; 0 = release the line (open-drain, the pad never drives high)
- `host_idx` input PTR_W: host read index
- `host_rdata` output 8: `reg[host_idx]`, combinational
- `wr_strobe` output 1: one-cycle pulse when a bus write commits a register
- `wr_idx` output PTR_W: register index written, valid with `wr_strobe`
- `wr_data` output 8: byte written, valid with `wr_strobe`
- `busy` output 1: high from address match until STOP or the transaction is abandoned

## Operation
**Bus detection**
- SCL and SDA pass through the synchroniser, then get edge detection.
- START / repeated START (Sr): synced SDA falls while synced SCL is high.
- STOP: synced SDA rises while synced SCL is high.
- START, Sr and STOP are detected in every state and take priority over bit processing in the same cycle.

**Bit timing on the bus**
- The target samples SDA on the SCL rising edge.
- The target changes `sda_oe` only on the SCL falling edge.

**States**
- IDLE → ADDR on START.
- ADDR: shift in 8 bits MSB-first.
  - Address match → ADDR_ACK.
  - Mismatch → IDLE, with `sda_oe` kept at 0 (NACK).
- ADDR_ACK: drive ACK for one SCL period, then:
  - R/W = 0 → PTR.
  - R/W = 1 → RD_DATA.
- PTR: receive 8 bits into the pointer.
  - Value < NUM_REGS → PTR_ACK → WR_DATA.
  - Otherwise NACK → IDLE, pointer unchanged.
- WR_DATA: receive 8 bits → WR_ACK.
  - At the 8th SCL rise, write the register and pulse `wr_strobe`.
  - Pointer increments and wraps from NUM_REGS-1 to 0.
- WR_ACK: drive ACK, then → WR_DATA.
- RD_DATA: shift out `reg[ptr]` MSB-first.
  - Drive `sda_oe = ~bit`.
  - The byte is latched at the SCL falling edge that ends the ACK.
  - After 8 bits → RD_ACK; pointer increments with wrap.
- RD_ACK: release SDA and sample the master's bit.
  - ACK (0) → RD_DATA.
  - NACK (1) → IDLE.
- Any state, STOP → IDLE.
- Any state, Sr → ADDR. The pointer is retained, which gives the standard write-pointer-then-Sr-read sequence.

**Outputs and flags**
- `busy` = state ∉ {IDLE}, and it is set only after an address match.
- Registers are written only from the bus. The host side is read-only.

## Timing
- Pin-to-internal latency: SYNC_STAGES + 1 clk cycles.
- `sda_oe` updates 1 clk after the detected SCL falling edge.
- `wr_strobe` asserts 1 clk after the detected 8th SCL rising edge of a data byte. It stays high exactly 1 cycle. `wr_idx`/`wr_data` are valid in that cycle.
- `host_rdata` has zero latency from `host_idx`. A bus write is visible on the cycle after `wr_strobe`.
- Reset (asynchronous, any time including mid-byte):
  - state IDLE, pointer 0, all registers 8'h00.
  - `sda_oe` 0, `wr_strobe` 0, `busy` 0, `wr_idx` 0, `wr_data` 0.
- After reset, the target ignores bus activity until the next START. A transfer in flight is abandoned.
- Simultaneous START and STOP are impossible on one SDA edge. STOP wins if the synchroniser shows both in one cycle.

## Structure
- Package `i2c_pkg`: the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK), `I2C_ADDR_W = 7`, `I2C_BYTE_W = 8`.
- Sub-module `i2c_bus_sync`: synchroniser, SCL rise/fall detection, START/STOP detection. It is shared with future I2C blocks.
- Top level: FSM, bit counter (3 bits), shift register, pointer, register array.

## Test plan
- Write burst: S, 0xF0 (addr 0x78 W), ptr 0x03, data 0xA5, 0x5A, P → ACK on all 4 bytes; `wr_strobe` twice with (3, 0xA5) then (4, 0x5A); `host_idx = 4` reads 0x5A.
- Pointer then read: S, 0xF0, ptr 0x03, Sr, 0xF1, read 2 bytes (ACK, then NACK), P → SDA shows 0xA5 then 0x5A; `busy` falls at P.
- Wrap: NUM_REGS = 16, write ptr 0x0F with 3 data bytes → `wr_idx` sequence is 15, 0, 1.
- Address mismatch / bad pointer: address 0x50 → `sda_oe` stays 0 for the whole frame and no strobe; ptr 0x20 with NUM_REGS = 16 → NACK and the pointer is unchanged.
- `rst_n` pulsed low mid-data-byte → `sda_oe` = 0 immediately and registers read 0x00; the next full write transaction succeeds.
